// File: rtl/sram_mem_controller_if.sv
// Pipeline-side bundle between the EXE/MEM stage registers and the SRAM data-memory controller.
// The pipeline is the master; the controller answers with read_data and the ready/freeze flag.
interface sram_mem_controller_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                  wr_en;
   logic                  rd_en;
   logic [31:0]           address;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  ready;

   modport master (
      output wr_en, rd_en, address, write_data,
      input  read_data, ready
   );

   modport slave (
      input  wr_en, rd_en, address, write_data,
      output read_data, ready
   );
endinterface

// File: rtl/sram_mem_controller.sv
// MEM-stage data memory backed by an external 16-bit asynchronous SRAM.
// Each 32-bit access is two half-word SRAM cycles followed by a fixed wait; ready=0 freezes the pipeline.
module sram_mem_controller #(
   parameter int DATA_WIDTH  = 32,
   parameter int SRAM_ADDR_W = 18,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   sram_mem_controller_if.slave    bus,
   output logic [SRAM_ADDR_W-1:0]  sram_addr,
   input  logic [15:0]             sram_dq_in,
   output logic [15:0]             sram_dq_out,
   output logic                    sram_dq_oe,
   output logic                    sram_we_n,
   output logic                    sram_oe_n
);

   localparam int WORD_W = SRAM_ADDR_W - 1;
   localparam int CNT_W  = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 2) ? CNT_W'(WAIT_CYCLES - 3) : '0;
   localparam logic [31:0] BASE = 32'(BASE_ADDR);

   typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

   state_t                  state;
   state_t                  next_state;
   logic                    op_write;
   logic [WORD_W-1:0]       word;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [CNT_W-1:0]        wait_cnt;
   logic [DATA_WIDTH-1:0]   read_data;
   logic                    ready;

   logic                    request;
   logic [31:0]             byte_off;
   logic                    unused_off_bits;
   logic                    cur_write;
   logic [WORD_W-1:0]       cur_word;
   logic [DATA_WIDTH-1:0]   cur_wdata;

   logic [SRAM_ADDR_W-1:0]  addr_d;
   logic [15:0]             dq_out_d;
   logic                    dq_oe_d;
   logic                    we_n_d;
   logic                    oe_n_d;

   assign request         = bus.rd_en | bus.wr_en;
   assign byte_off        = bus.address - BASE;
   assign unused_off_bits = ^{byte_off[31:SRAM_ADDR_W+1], byte_off[1:0]};
   assign bus.read_data   = read_data;
   assign bus.ready       = ready;

   // In IDLE the request is still on the bus, so the first half is set up from the live inputs.
   always_comb begin
      cur_write = op_write;
      cur_word  = word;
      cur_wdata = wdata;
      if (state == IDLE) begin
         cur_write = bus.wr_en;
         cur_word  = byte_off[SRAM_ADDR_W:2];
         cur_wdata = bus.write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      ready      = 1'b0;
      case (state)
         IDLE: begin
            ready = ~request;
            if (request) begin
               next_state = LOW;
            end
         end
         LOW:     next_state = HIGH;
         HIGH:    next_state = (WAIT_CYCLES > 2) ? WAIT : DONE;
         WAIT: begin
            if (wait_cnt == '0) begin
               next_state = DONE;
            end
         end
         DONE: begin
            ready      = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // SRAM pins are registered against next_state so each value holds for the whole state cycle.
   always_comb begin
      addr_d   = sram_addr;
      dq_out_d = sram_dq_out;
      dq_oe_d  = 1'b0;
      we_n_d   = 1'b1;
      oe_n_d   = 1'b1;
      case (next_state)
         LOW, HIGH: begin
            addr_d = {cur_word, (next_state == HIGH)};
            if (cur_write) begin
               dq_out_d = (next_state == HIGH) ? cur_wdata[DATA_WIDTH-1:16] : cur_wdata[15:0];
               dq_oe_d  = 1'b1;
               we_n_d   = 1'b0;
            end else begin
               oe_n_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op_write    <= 1'b0;
         word        <= '0;
         wdata       <= '0;
         wait_cnt    <= '0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
      end else begin
         sram_addr   <= addr_d;
         sram_dq_out <= dq_out_d;
         sram_dq_oe  <= dq_oe_d;
         sram_we_n   <= we_n_d;
         sram_oe_n   <= oe_n_d;
         if (state == IDLE && request) begin
            op_write <= bus.wr_en;
            word     <= cur_word;
            wdata    <= bus.write_data;
         end
         if (state == HIGH) begin
            wait_cnt <= WAIT_LOAD;
         end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end
         if (state == LOW && !op_write) begin
            read_data[15:0] <= sram_dq_in;
         end
         if (state == HIGH && !op_write) begin
            read_data[DATA_WIDTH-1:16] <= sram_dq_in;
         end
      end
   end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench: a request-level model checks the WAIT_CYCLES=5 controller every cycle,
// directed vectors pin the model, and a second WAIT_CYCLES=2 instance covers the no-wait corner.
module tb_sram_mem_controller;

   localparam int W5 = 5;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   sram_mem_controller_if #(.DATA_WIDTH(32)) bus5 ();
   sram_mem_controller_if #(.DATA_WIDTH(32)) bus2 ();

   logic [17:0] s5_addr, s2_addr;
   logic [15:0] s5_dq_in, s5_dq_out, s2_dq_in, s2_dq_out;
   logic        s5_dq_oe, s5_we_n, s5_oe_n, s2_dq_oe, s2_we_n, s2_oe_n;

   sram_mem_controller #(
      .DATA_WIDTH(32), .SRAM_ADDR_W(18), .BASE_ADDR(1024), .WAIT_CYCLES(5)
   ) dut5 (
      .clk(clk), .rst(rst), .bus(bus5),
      .sram_addr(s5_addr), .sram_dq_in(s5_dq_in), .sram_dq_out(s5_dq_out),
      .sram_dq_oe(s5_dq_oe), .sram_we_n(s5_we_n), .sram_oe_n(s5_oe_n)
   );

   sram_mem_controller #(
      .DATA_WIDTH(32), .SRAM_ADDR_W(18), .BASE_ADDR(1024), .WAIT_CYCLES(2)
   ) dut2 (
      .clk(clk), .rst(rst), .bus(bus2),
      .sram_addr(s2_addr), .sram_dq_in(s2_dq_in), .sram_dq_out(s2_dq_out),
      .sram_dq_oe(s2_dq_oe), .sram_we_n(s2_we_n), .sram_oe_n(s2_oe_n)
   );

   // Asynchronous SRAM models: write while we_n is low, drive data while oe_n is low.
   logic [15:0] sram5 [0:255];
   logic [15:0] sram2 [0:255];

   always @(posedge clk) if (!s5_we_n) sram5[s5_addr[7:0]] <= s5_dq_out;
   always @(posedge clk) if (!s2_we_n) sram2[s2_addr[7:0]] <= s2_dq_out;

   assign s5_dq_in = s5_oe_n ? 16'hDEAD : sram5[s5_addr[7:0]];
   assign s2_dq_in = s2_oe_n ? 16'hDEAD : sram2[s2_addr[7:0]];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic int wordOf(input logic [31:0] a);
      logic [31:0] d;
      d = a - 32'd1024;
      return int'((d >> 2) & 32'h0001_FFFF);
   endfunction

   // Request-level model: a request seen in an idle cycle owns the next W5+1 cycles;
   // cycles 1 and 2 of it are the low and high half accesses, the last one reports ready.
   bit          m_busy  = 1'b0;
   int          m_phase = 0;
   bit          m_write;
   int          m_word;
   logic [31:0] m_data;
   logic [31:0] exp_rd  = '0;
   logic [15:0] exp_mem [0:255];

   always @(negedge clk) begin : model
      int          half;
      int          e_addr;
      logic [15:0] e_half;
      if (rst !== 1'b1) begin
         m_busy  = 1'b0;
         m_phase = 0;
         exp_rd  = '0;
      end else begin
         checkOutput("read_data", bus5.read_data, exp_rd);
         if (!m_busy) begin
            checkOutput("ready_idle", bus5.ready, (bus5.wr_en | bus5.rd_en) ? 0 : 1);
            checkOutput("we_n_idle", s5_we_n, 1);
            checkOutput("oe_n_idle", s5_oe_n, 1);
            checkOutput("dq_oe_idle", s5_dq_oe, 0);
            if (bus5.wr_en | bus5.rd_en) begin
               m_busy  = 1'b1;
               m_phase = 1;
               m_write = bus5.wr_en;
               m_word  = wordOf(bus5.address);
               m_data  = bus5.write_data;
            end
         end else begin
            checkOutput("ready_busy", bus5.ready, (m_phase == W5 + 1) ? 1 : 0);
            if (m_phase <= 2) begin
               half   = m_phase - 1;
               e_addr = m_word * 2 + half;
               e_half = (half == 1) ? m_data[31:16] : m_data[15:0];
               checkOutput("sram_addr", s5_addr, e_addr);
               if (m_write) begin
                  checkOutput("we_n_write", s5_we_n, 0);
                  checkOutput("oe_n_write", s5_oe_n, 1);
                  checkOutput("dq_oe_write", s5_dq_oe, 1);
                  checkOutput("dq_out", s5_dq_out, e_half);
                  exp_mem[e_addr & 255] = e_half;
               end else begin
                  checkOutput("we_n_read", s5_we_n, 1);
                  checkOutput("oe_n_read", s5_oe_n, 0);
                  checkOutput("dq_oe_read", s5_dq_oe, 0);
                  if (half == 0) exp_rd[15:0]  = exp_mem[e_addr & 255];
                  else           exp_rd[31:16] = exp_mem[e_addr & 255];
               end
            end else begin
               checkOutput("we_n_wait", s5_we_n, 1);
               checkOutput("oe_n_wait", s5_oe_n, 1);
               checkOutput("dq_oe_wait", s5_dq_oe, 0);
            end
            if (m_phase == W5 + 1) m_busy = 1'b0;
            else                   m_phase++;
         end
      end
   end

   // Presents one request (called just after a rising edge) and holds it until ready, like a frozen pipeline.
   task automatic applyStimulus(input bit sel, input logic wr, input logic rd, input logic [31:0] addr,
                                input logic [31:0] data, output int low_cnt, output logic [31:0] rd_at_done);
      bit done;
      if (sel) begin
         bus2.wr_en = wr; bus2.rd_en = rd; bus2.address = addr; bus2.write_data = data;
      end else begin
         bus5.wr_en = wr; bus5.rd_en = rd; bus5.address = addr; bus5.write_data = data;
      end
      low_cnt    = 0;
      rd_at_done = '0;
      done       = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if ((sel ? bus2.ready : bus5.ready) === 1'b1) begin
            done       = 1'b1;
            rd_at_done = sel ? bus2.read_data : bus5.read_data;
         end else begin
            low_cnt++;
         end
      end
      if (!done) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL ready_timeout: got no ready within 40 cycles, expected ready");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleBus();
      bus5.wr_en = 1'b0; bus5.rd_en = 1'b0;
      bus2.wr_en = 1'b0; bus2.rd_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lc, lc_b;
      logic [31:0] rdv;
      rst = 1'b0;
      bus5.wr_en = 1'b0; bus5.rd_en = 1'b0; bus5.address = '0; bus5.write_data = '0;
      bus2.wr_en = 1'b0; bus2.rd_en = 1'b0; bus2.address = '0; bus2.write_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      @(negedge clk);
      checkOutput("reset_ready", bus5.ready, 1);
      checkOutput("reset_read_data", bus5.read_data, 0);
      checkOutput("reset_sram_addr", s5_addr, 0);
      checkOutput("reset_dq_out", s5_dq_out, 0);
      checkOutput("reset_we_n", s5_we_n, 1);
      checkOutput("reset_oe_n", s5_oe_n, 1);
      checkOutput("reset_dq_oe", s5_dq_oe, 0);
      @(posedge clk);
      #1;

      $display("[TB] T1 write 1024");
      applyStimulus(0, 1, 0, 32'd1024, 32'h1234_5678, lc, rdv);
      checkOutput("t1_ready_low", lc, 6);
      checkOutput("t1_mem0", sram5[0], 16'h5678);
      checkOutput("t1_mem1", sram5[1], 16'h1234);
      idleBus();

      $display("[TB] T2 read 1024");
      applyStimulus(0, 0, 1, 32'd1024, 32'h0, lc, rdv);
      checkOutput("t2_ready_low", lc, 6);
      checkOutput("t2_read_data", rdv, 32'h1234_5678);
      idleBus();

      $display("[TB] T3 write 1032");
      applyStimulus(0, 1, 0, 32'd1032, 32'hAABB_CCDD, lc, rdv);
      checkOutput("t3_mem4", sram5[4], 16'hCCDD);
      checkOutput("t3_mem5", sram5[5], 16'hAABB);
      checkOutput("t3_mem0", sram5[0], 16'h5678);
      checkOutput("t3_mem1", sram5[1], 16'h1234);
      idleBus();

      $display("[TB] T4 back-to-back write/read 1028");
      applyStimulus(0, 1, 0, 32'd1028, 32'hCAFE_F00D, lc, rdv);
      checkOutput("t4_rd_during_write", rdv, 32'h1234_5678);
      applyStimulus(0, 0, 1, 32'd1028, 32'h0, lc_b, rdv);
      checkOutput("t4_total_ready_low", lc + lc_b, 12);
      checkOutput("t4_read_data", rdv, 32'hCAFE_F00D);
      idleBus();

      $display("[TB] T6 rd_en and wr_en together");
      applyStimulus(0, 1, 1, 32'd1040, 32'h0BAD_BEEF, lc, rdv);
      checkOutput("t6_ready_low", lc, 6);
      checkOutput("t6_rd_unchanged", rdv, 32'hCAFE_F00D);
      checkOutput("t6_mem8", sram5[8], 16'hBEEF);
      checkOutput("t6_mem9", sram5[9], 16'h0BAD);
      idleBus();
      applyStimulus(0, 0, 1, 32'd1040, 32'h0, lc, rdv);
      checkOutput("t6_read_back", rdv, 32'h0BAD_BEEF);
      idleBus();

      $display("[TB] T5 reset during high half of a write");
      bus5.wr_en = 1'b1; bus5.address = 32'd1036; bus5.write_data = 32'h5555_6666;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("t5_high_addr", s5_addr, 7);
      checkOutput("t5_high_we_n", s5_we_n, 0);
      rst = 1'b0;
      bus5.wr_en = 1'b0;
      @(posedge clk); #1;
      checkOutput("t5_ready", bus5.ready, 1);
      checkOutput("t5_we_n", s5_we_n, 1);
      checkOutput("t5_dq_oe", s5_dq_oe, 0);
      checkOutput("t5_oe_n", s5_oe_n, 1);
      checkOutput("t5_read_data", bus5.read_data, 0);
      checkOutput("t5_sram_addr", s5_addr, 0);
      checkOutput("t5_mem6", sram5[6], 16'h6666);
      rst = 1'b1;
      idleBus();

      applyStimulus(0, 0, 1, 32'd1032, 32'h0, lc, rdv);
      checkOutput("post_reset_read", rdv, 32'hAABB_CCDD);
      idleBus();

      $display("[TB] T6 WAIT_CYCLES=2 instance");
      applyStimulus(1, 1, 0, 32'd1024, 32'h1111_2222, lc, rdv);
      checkOutput("w2_write_ready_low", lc, 3);
      checkOutput("w2_mem0", sram2[0], 16'h2222);
      checkOutput("w2_mem1", sram2[1], 16'h1111);
      idleBus();
      applyStimulus(1, 0, 1, 32'd1024, 32'h0, lc, rdv);
      checkOutput("w2_read_ready_low", lc, 3);
      checkOutput("w2_read_data", rdv, 32'h1111_2222);
      idleBus();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
